// File: rtl/viterbi_traceback_unit_if.sv
// Handshake/bus bundle between the ACS stage, this traceback unit and the output block.
// Ports: i_valid/i_decision/i_last/i_best_state (ACS decisions in),
//        o_ready/o_valid/o_data/o_start/o_overflow (decoded bits out, status).
interface viterbi_traceback_unit_if #(
  parameter int K          = 3,
  parameter int STATE_W    = K - 1,
  parameter int NUM_STATES = 2 ** (K - 1)
);
  logic                  i_valid;
  logic [NUM_STATES-1:0] i_decision;
  logic                  i_last;
  logic [STATE_W-1:0]    i_best_state;
  logic                  o_ready;
  logic                  o_valid;
  logic                  o_data;
  logic                  o_start;
  logic                  o_overflow;

  // Producer of decisions / consumer of decoded bits.
  modport master (
    output i_valid, i_decision, i_last, i_best_state,
    input  o_ready, o_valid, o_data, o_start, o_overflow
  );

  // The traceback unit itself.
  modport slave (
    input  i_valid, i_decision, i_last, i_best_state,
    output o_ready, o_valid, o_data, o_start, o_overflow
  );
endinterface

// File: rtl/viterbi_traceback_unit.sv
// Survivor memory + traceback: stores one decision vector per step, traces back at frame end,
// then replays decoded bits in time order. Latency: i_last accept -> first o_valid = len+1 cycles.
// Backpressure: o_ready only in COLLECT; output side never stalls. Optional: VITERBI_ZERO_TAIL_EN.
// Ports: i_clk, i_rst_n (sync, active-low) plus bus (slave modport of viterbi_traceback_unit_if).
// VITERBI_ZERO_TAIL_EN: trace from state 0 and drop the last K-1 traced bits of each frame.
module viterbi_traceback_unit #(
  parameter int K          = 3,
  parameter int NUM_STATES = 2 ** (K - 1),
  parameter int STATE_W    = K - 1,
  parameter int MAX_LEN    = 64,
  parameter int BYTE_W     = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  viterbi_traceback_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_LEN);
  localparam int LEN_W = CNT_W + 1;
  localparam int BC_W  = $clog2(BYTE_W);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_TRACE   = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      t_q, t_d;
  logic [STATE_W-1:0]    s_q, s_d;
  logic [LEN_W-1:0]      r_q, r_d;
  logic [BC_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic                  start_q, start_d;
  logic                  overflow_q, overflow_d;
  logic [NUM_STATES-1:0] mem_q [MAX_LEN];
  logic [NUM_STATES-1:0] mem_d [MAX_LEN];
  logic [MAX_LEN-1:0]    bitbuf_q, bitbuf_d;

  logic                  ready;
  logic                  valid;
  logic                  data;
  logic [LEN_W-1:0]      out_len;
  logic [STATE_W-1:0]    start_state;
  logic                  last_out;

  // Number of bits replayed per frame and the state traceback starts from.
`ifdef VITERBI_ZERO_TAIL_EN
  assign out_len     = (len_q > LEN_W'(K - 1)) ? (len_q - LEN_W'(K - 1)) : '0;
  assign start_state = '0;
`else
  assign out_len     = len_q;
  assign start_state = bus.i_best_state;
`endif

  assign last_out = (r_q == (out_len - LEN_W'(1)));

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    len_d      = len_q;
    t_d        = t_q;
    s_d        = s_q;
    r_d        = r_q;
    byte_cnt_d = byte_cnt_q;
    start_d    = 1'b0;
    overflow_d = overflow_q;
    mem_d      = mem_q;
    bitbuf_d   = bitbuf_q;
    ready      = 1'b0;
    valid      = 1'b0;
    data       = 1'b0;

    unique case (state_q)
      ST_COLLECT: begin
        ready = 1'b1;
        if (bus.i_valid) begin
          mem_d[wr_cnt_q] = bus.i_decision;
          // A full memory closes the frame as if i_last had arrived.
          if (bus.i_last || (wr_cnt_q == CNT_W'(MAX_LEN - 1))) begin
            len_d    = {1'b0, wr_cnt_q} + LEN_W'(1);
            t_d      = wr_cnt_q;
            s_d      = start_state;
            wr_cnt_d = '0;
            state_d  = ST_TRACE;
            if (!bus.i_last) begin
              overflow_d = 1'b1;
            end
          end else begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_TRACE: begin
        // The state MSB is the input bit that entered at step t; the stored
        // decision supplies the bit shifted out, giving the predecessor state.
        bitbuf_d[t_q] = s_q[STATE_W-1];
        s_d           = {s_q[STATE_W-2:0], mem_q[t_q][s_q]};
        t_d           = t_q - CNT_W'(1);
        r_d           = '0;
        byte_cnt_d    = '0;
        if (t_q == '0) begin
          state_d = (out_len == '0) ? ST_COLLECT : ST_OUTPUT;
        end
      end

      ST_OUTPUT: begin
        valid      = 1'b1;
        data       = bitbuf_q[r_q[CNT_W-1:0]];
        r_d        = r_q + LEN_W'(1);
        byte_cnt_d = byte_cnt_q + BC_W'(1);
        // Byte boundary and final-bit flush share one pulse.
        if ((byte_cnt_q == BC_W'(BYTE_W - 1)) || last_out) begin
          start_d = 1'b1;
        end
        if (last_out) begin
          state_d = ST_COLLECT;
        end
      end

      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_COLLECT;
      wr_cnt_q   <= '0;
      len_q      <= '0;
      t_q        <= '0;
      s_q        <= '0;
      r_q        <= '0;
      byte_cnt_q <= '0;
      start_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      len_q      <= len_d;
      t_q        <= t_d;
      s_q        <= s_d;
      r_q        <= r_d;
      byte_cnt_q <= byte_cnt_d;
      start_q    <= start_d;
      overflow_q <= overflow_d;
    end
  end

  // Survivor memory and bit buffer hold pure data; their contents are
  // always rewritten before being read, so they carry no reset.
  always_ff @(posedge i_clk) begin
    mem_q    <= mem_d;
    bitbuf_q <= bitbuf_d;
  end

  assign bus.o_ready    = ready;
  assign bus.o_valid    = valid;
  assign bus.o_data     = data;
  assign bus.o_start    = start_q;
  assign bus.o_overflow = overflow_q;

endmodule
